async_bus_master: RTL
=====================

Name: async_bus_master

Overview:
- Initiator side of the 16-bit CE/OE/WE parallel GPIO bus. It lets an FPGA-side host perform single-word writes and reads against a bus responder, such as the shift-register slave on the companion board.
- Converts a valid/ready request interface into timed, active-low CE/OE/WE strobe sequences with tristate data control.
- Phase lengths are set by parameters so that the responder's two-flop edge detector sees clean edges.

Parameters:
- DW, 16, data bus width.
- T_SETUP, 3, cycles from CE low to OE/WE strobe phase. Must be >= 3 so the responder has released the data bus before a write drives it.
- T_STROBE, 4, cycles OE or WE is held low. Must be >= 2.
- T_HOLD, 2, cycles after the strobe rises with CE still low. Must be >= 2.
- CW, 4, phase counter width. Must be able to hold max(T_*).

Ports:
- clock, input, 1: single system clock; all logic is on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: host request present.
- req_ready, output, 1: master is idle and can accept a request.
- req_write, input, 1: 1 = write, 0 = read. Sampled on accept.
- req_wdata, input, DW: write data. Sampled on accept.
- rsp_valid, output, 1: one-cycle pulse; rsp_rdata is valid.
- rsp_rdata, output, DW: read data. Holds its value until the next read.
- wr_done, output, 1: one-cycle pulse when a write completes.
- bus_ce_n, output, 1: chip enable, active low.
- bus_oe_n, output, 1: output enable, active low.
- bus_we_n, output, 1: write enable, active low. The responder captures data on its rising edge.
- bus_d_out, output, DW: data to the pad driver.
- bus_d_oe, output, 1: 1 = drive pads with bus_d_out; 0 = high-Z.
- bus_d_in, input, DW: pad input data.

Behaviour:
- Reset, asynchronous and immediate, including mid-transaction:
  - state = IDLE.
  - bus_ce_n, bus_oe_n, bus_we_n = 1.
  - bus_d_oe = 0, bus_d_out = 0.
  - rsp_valid = 0, wr_done = 0, rsp_rdata = 0.
  - No partial transaction resumes after reset.
- req_ready = 1 only in IDLE. A request is accepted when req_valid & req_ready. req_write and req_wdata are latched at accept.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - Each non-IDLE state lasts exactly its T_* cycles. The phase counter reloads on every state entry.
  - After HOLD, the FSM returns to IDLE, which lasts at least 1 cycle. CE is therefore high for >= 1 cycle between back-to-back transactions.
- Write sequence:
  - SETUP: ce_n = 0, we_n = 0, d_oe = 0. WE falls first so the responder stops driving.
  - STROBE: we_n = 0, d_oe = 1, d_out = wdata.
  - HOLD: we_n = 1 (rising edge), d_oe = 1, data stable.
  - Next cycle after HOLD: d_oe = 0, ce_n = 1, and wr_done pulses for 1 cycle.
  - Total duration: T_SETUP + T_STROBE + T_HOLD cycles, accept cycle excluded.
- Read sequence:
  - SETUP: ce_n = 0, oe_n = 1, we_n = 1, d_oe = 0.
  - STROBE: oe_n = 0.
  - rsp_rdata <= bus_d_in on the last STROBE cycle. rsp_valid pulses in the first HOLD cycle.
  - HOLD: oe_n = 1, ce_n = 0.
  - The master never drives data during a read or in IDLE. After a read the responder keeps driving until the next WE fall, which is why writes assert WE before d_oe.
- Output timing and encoding:
  - All bus outputs come directly from flops; no combinational path from req_* to bus_*.
  - oe_n and we_n are never both low.
  - d_oe = 1 only while we_n was low or in the HOLD of a write.
- req_valid asserted in a non-IDLE state: ignored; not latched.

Optional Feature:
- Macro: ASYNC_BUS_MASTER_DIN_REG_EN.
- When defined:
  - bus_d_in passes through an input register before sampling; the capture uses the registered value from the last STROBE cycle.
  - STROBE is extended by 1 cycle.
  - rsp_valid and rsp_rdata are delayed by 1 cycle relative to the undefined case.
  - Write timing is unchanged.
- When undefined: direct sampling as described under Behaviour.

Test Plan:
1. Reset values: assert reset mid-STROBE of a write. Same cycle (asynchronous): ce_n = oe_n = we_n = 1, d_oe = 0, req_ready = 1 after release. No wr_done pulse.
2. Write 0xBEEF with defaults:
   - accept at cycle 0;
   - cycles 1-3: ce_n = 0, we_n = 0, d_oe = 0;
   - cycles 4-7: d_oe = 1, d_out = 0xBEEF;
   - cycles 8-9: we_n = 1, d_oe = 1;
   - cycle 10: ce_n = 1, d_oe = 0, wr_done = 1.
3. Read with responder model driving 0x1234 while oe_n = 0. rsp_rdata = 0x1234 with rsp_valid high in cycle 8 (first HOLD cycle); d_oe = 0 throughout.
4. Back-to-back: req_valid held high with write 0xA5A5 then read. ce_n = 1 for exactly 1 cycle between them; req_ready low during each transaction; oe_n and we_n never both low.
5. Bus contention check: read, then immediately a write. d_oe rises no earlier than T_SETUP cycles after we_n falls, and the responder model's drive has released before d_oe = 1.
6. ASYNC_BUS_MASTER_DIN_REG_EN defined: read of 0x00FF gives rsp_valid one cycle later than in scenario 3, with correct data. Write timing is identical to scenario 2.

Source files
------------

// File: rtl/async_bus_master.sv
// Initiator for the 16-bit CE/OE/WE parallel GPIO bus: turns valid/ready host requests into timed strobe sequences.
// Optional input-register on bus_d_in: define ASYNC_BUS_MASTER_DIN_REG_EN (extends read STROBE by one cycle).

// state  | meaning
// IDLE   | CE high, bus released, req_ready asserted
// SETUP  | CE low; WE low for writes so the responder releases the data bus
// STROBE | OE low (read) or WE low with data driven (write)
// HOLD   | strobe released, CE still low; write data still driven
module async_bus_master #(
    parameter int DW       = 16,
    parameter int T_SETUP  = 3,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2,
    parameter int CW       = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          wr_done,
    output logic          bus_ce_n,
    output logic          bus_oe_n,
    output logic          bus_we_n,
    output logic [DW-1:0] bus_d_out,
    output logic          bus_d_oe,
    input  logic [DW-1:0] bus_d_in
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    logic [DW-1:0] din_sample;

`ifdef ASYNC_BUS_MASTER_DIN_REG_EN
    localparam int RD_EXTRA = 1;
    logic [DW-1:0] din_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) din_q <= '0;
        else       din_q <= bus_d_in;
    end

    assign din_sample = din_q;
`else
    localparam int RD_EXTRA = 0;

    assign din_sample = bus_d_in;
`endif

    // Counter load values are one less than the phase length: the phase ends on terminal count zero.
    localparam logic [CW-1:0] LD_SETUP     = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE_WR = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_STROBE_RD = CW'(T_STROBE + RD_EXTRA - 1);
    localparam logic [CW-1:0] LD_HOLD      = CW'(T_HOLD - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          is_wr, is_wr_nxt;
    logic [DW-1:0] wdata, wdata_nxt;
    logic          capture;
    logic          wr_done_nxt;

    logic          ce_nxt, oe_nxt, we_nxt, doe_nxt;
    logic [DW-1:0] dout_nxt;

    assign req_ready = (state == IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            is_wr <= 1'b0;
            wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            is_wr <= is_wr_nxt;
            wdata <= wdata_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        is_wr_nxt   = is_wr;
        wdata_nxt   = wdata;
        capture     = 1'b0;
        wr_done_nxt = 1'b0;

        if (state != IDLE) cnt_nxt = cnt - CW'(1);

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt = SETUP;
                    cnt_nxt   = LD_SETUP;
                    is_wr_nxt = req_write;
                    wdata_nxt = req_wdata;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = STROBE;
                    cnt_nxt   = is_wr ? LD_STROBE_WR : LD_STROBE_RD;
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = LD_HOLD;
                    capture   = !is_wr;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    wr_done_nxt = is_wr;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Bus pins are decoded from the next state so they change on the same edge as the state register.
    always_comb begin
        ce_nxt   = 1'b1;
        oe_nxt   = 1'b1;
        we_nxt   = 1'b1;
        doe_nxt  = 1'b0;
        dout_nxt = '0;

        case (state_nxt)
            SETUP: begin
                ce_nxt = 1'b0;
                we_nxt = !is_wr_nxt;
            end
            STROBE: begin
                ce_nxt  = 1'b0;
                we_nxt  = !is_wr_nxt;
                oe_nxt  = is_wr_nxt;
                doe_nxt = is_wr_nxt;
                if (is_wr_nxt) dout_nxt = wdata_nxt;
            end
            HOLD: begin
                ce_nxt  = 1'b0;
                doe_nxt = is_wr_nxt;
                if (is_wr_nxt) dout_nxt = wdata_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus_ce_n  <= 1'b1;
            bus_oe_n  <= 1'b1;
            bus_we_n  <= 1'b1;
            bus_d_oe  <= 1'b0;
            bus_d_out <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_done   <= 1'b0;
        end else begin
            bus_ce_n  <= ce_nxt;
            bus_oe_n  <= oe_nxt;
            bus_we_n  <= we_nxt;
            bus_d_oe  <= doe_nxt;
            bus_d_out <= dout_nxt;
            rsp_valid <= capture;
            wr_done   <= wr_done_nxt;
            if (capture) rsp_rdata <= din_sample;
        end
    end

endmodule
